// File: rtl/demux_1x2_32bit_buf_pkg.sv
// Shared types and constants for the 1-to-2 registered demux.
package demux_1x2_32bit_buf_pkg;
  localparam int DEMUX_WIDTH = 32;
  localparam int NUM_OUT     = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/demux_1x2_32bit_buf_if.sv
// Producer/consumer bus of the 1-to-2 demux; slave is the demux side.
interface demux_1x2_32bit_buf_if #(
  parameter int WIDTH = demux_1x2_32bit_buf_pkg::DEMUX_WIDTH
);
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             select;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1;
  logic             out1_valid;
  logic             out1_ready;

  modport slave (
    input  in_word, in_valid, select, out0_ready, out1_ready,
    output in_ready, out0, out0_valid, out1, out1_valid
  );

  modport master (
    output in_word, in_valid, select, out0_ready, out1_ready,
    input  in_ready, out0, out0_valid, out1, out1_valid
  );
endinterface

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid/ready and flush.
module demux_out_slot
  import demux_1x2_32bit_buf_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             ready,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             free
);
  slot_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = SLOT_FULL;
    else if (state_q == SLOT_FULL && ready)
      state_d = SLOT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      word    <= '0;
    end else begin
      state_q <= flush ? SLOT_EMPTY : state_d;
      if (load) word <= load_word;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  // Free means an incoming word can land at the next edge: empty or draining now.
  assign free  = !valid || ready;
endmodule

// File: rtl/demux_1x2_32bit_buf.sv
// Registered 1-to-2 demux with a holding slot per branch.
// Optional macro DEMUX_STRICT_ORDER_EN keeps global issue order across branches.
module demux_1x2_32bit_buf
  import demux_1x2_32bit_buf_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  demux_1x2_32bit_buf_if.slave  bus
);
  logic [NUM_OUT-1:0]            ready, valid, free, load;
  logic [NUM_OUT-1:0][WIDTH-1:0] word;
  logic                          order_ok, in_ready, accept;

  assign ready = {bus.out1_ready, bus.out0_ready};

`ifdef DEMUX_STRICT_ORDER_EN
  // The other branch must be empty or draining so nothing overtakes an older word.
  assign order_ok = free[~bus.select];
`else
  assign order_ok = 1'b1;
`endif

  assign in_ready     = !reset && !flush && free[bus.select] && order_ok;
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    assign load[g] = accept && (bus.select == 1'(g));

    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (load[g]),
      .load_word (bus.in_word),
      .ready     (ready[g]),
      .word      (word[g]),
      .valid     (valid[g]),
      .free      (free[g])
    );
  end

  assign bus.out0       = word[0];
  assign bus.out0_valid = valid[0];
  assign bus.out1       = word[1];
  assign bus.out1_valid = valid[1];
endmodule

// File: tb/tb_demux_1x2_32bit_buf.sv
// Directed vector table, streaming sequence and randomized run against a queue model.
module tb_demux_1x2_32bit_buf;
`ifdef DEMUX_STRICT_ORDER_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush;
  int   vectors = 0;
  int   miscompares = 0;

  demux_1x2_32bit_buf_if #(.WIDTH(32)) bus ();

  demux_1x2_32bit_buf #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, iv, sel;
    logic [31:0] d;
    logic        r0, r1;
    logic        e_rdy, e_v0;
    logic [31:0] e_o0;
    logic        e_v1;
    logic [31:0] e_o1;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic sel, logic [31:0] d,
                              logic r0, logic r1, logic e_rdy, logic e_v0, logic [31:0] e_o0,
                              logic e_v1, logic [31:0] e_o1);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.sel = sel; v.d = d; v.r0 = r0; v.r1 = r1;
    v.e_rdy = e_rdy; v.e_v0 = e_v0; v.e_o0 = e_o0; v.e_v1 = e_v1; v.e_o1 = e_o1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic fl, logic iv, logic sel, logic [31:0] d,
                       logic r0, logic r1);
    reset = rst; flush = fl;
    bus.in_valid = iv; bus.select = sel; bus.in_word = d;
    bus.out0_ready = r0; bus.out1_ready = r1;
  endtask

  logic [31:0] q0[$], q1[$];

  initial begin
    // rst fl iv sel d             r0 r1  rdy v0 o0            v1 o1
    tbl[0]  = mk(1, 0, 1, 0, 32'hA5A5A5A5, 0, 0,  0, 0, 32'h0,        0, 32'h0);
    tbl[1]  = mk(1, 0, 1, 0, 32'hA5A5A5A5, 0, 0,  0, 0, 32'h0,        0, 32'h0);
    tbl[2]  = mk(0, 0, 1, 0, 32'hA5A5A5A5, 0, 0,  1, 0, 32'h0,        0, 32'h0);
    tbl[3]  = mk(0, 0, 1, 1, 32'hDEADBEEF, 1, 1,  1, 1, 32'hA5A5A5A5, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,        0, 1,  1, 0, 32'hA5A5A5A5, 1, 32'hDEADBEEF);
    tbl[5]  = mk(0, 0, 1, 0, 32'h1,        0, 0,  1, 0, 32'hA5A5A5A5, 0, 32'hDEADBEEF);
    tbl[6]  = mk(0, 0, 1, 0, 32'h2,        0, 0,  0, 1, 32'h1,        0, 32'hDEADBEEF);
    tbl[7]  = mk(0, 0, 1, 0, 32'h2,        0, 0,  0, 1, 32'h1,        0, 32'hDEADBEEF);
    tbl[8]  = mk(0, 0, 1, 0, 32'h2,        1, 0,  1, 1, 32'h1,        0, 32'hDEADBEEF);
    tbl[9]  = mk(0, 0, 0, 0, 32'h0,        1, 0,  1, 1, 32'h2,        0, 32'hDEADBEEF);
    tbl[10] = mk(0, 0, 1, 0, 32'h11,       0, 0,  1, 0, 32'h2,        0, 32'hDEADBEEF);
    tbl[11] = mk(0, 0, 1, 1, 32'h22,       0, 0,  !STRICT, 1, 32'h11, 0, 32'hDEADBEEF);
    tbl[12] = mk(0, 1, 1, 0, 32'h33,       0, 0,  0, 1, 32'h11, !STRICT,
                 STRICT ? 32'hDEADBEEF : 32'h22);
    tbl[13] = mk(0, 0, 0, 0, 32'h0,        0, 0,  1, 0, 32'h11, 0,
                 STRICT ? 32'hDEADBEEF : 32'h22);

    drive(1, 0, 0, 0, 32'h0, 0, 0);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("tbl%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d out0_valid", i), 32'(bus.out0_valid), 32'(tbl[i].e_v0));
      chk($sformatf("tbl%0d out0", i), bus.out0, tbl[i].e_o0);
      chk($sformatf("tbl%0d out1_valid", i), 32'(bus.out1_valid), 32'(tbl[i].e_v1));
      chk($sformatf("tbl%0d out1", i), bus.out1, tbl[i].e_o1);
      @(negedge clk);
    end

    // Back-to-back stream 0..7 into branch 0: no bubbles, in order.
    for (int i = 0; i <= 8; i++) begin
      drive(0, 0, (i < 8), 0, 32'(i), 1, 1);
      #1;
      chk($sformatf("stream%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("stream%0d out0_valid", i), 32'(bus.out0_valid), 32'(i > 0));
      if (i > 0) chk($sformatf("stream%0d out0", i), bus.out0, 32'(i - 1));
      @(negedge clk);
    end

    q0.delete(); q1.delete();
    for (int n = 0; n < 1500; n++) begin
      logic r, f, iv, s, r0, r1, exp_rdy, sel_ok, oth_ok;
      logic [31:0] d;
      r  = ($urandom_range(63) == 0);
      f  = ($urandom_range(15) == 0);
      iv = 1'($urandom_range(1));
      s  = 1'($urandom_range(1));
      d  = $urandom;
      r0 = ($urandom_range(3) != 0);
      r1 = ($urandom_range(3) != 0);
      drive(r, f, iv, s, d, r0, r1);
      #1;
      sel_ok  = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
      oth_ok  = s ? (q0.size() == 0 || r0) : (q1.size() == 0 || r1);
      exp_rdy = !r && !f && sel_ok && (!STRICT || oth_ok);
      chk($sformatf("rand%0d in_ready", n), 32'(bus.in_ready), 32'(exp_rdy));
      chk($sformatf("rand%0d out0_valid", n), 32'(bus.out0_valid), 32'(q0.size() != 0));
      chk($sformatf("rand%0d out1_valid", n), 32'(bus.out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk($sformatf("rand%0d out0", n), bus.out0, q0[0]);
      if (q1.size() != 0) chk($sformatf("rand%0d out1", n), bus.out1, q1[0]);
      if (r || f) begin
        q0.delete(); q1.delete();
      end else begin
        if (q0.size() != 0 && r0) void'(q0.pop_front());
        if (q1.size() != 0 && r1) void'(q1.pop_front());
        if (iv && exp_rdy) begin
          if (s) q1.push_back(d);
          else   q0.push_back(d);
        end
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
